// File: rtl/issue_scoreboard_if.sv
// Decode-queue / execution-pipe side signals of the issue stage, bundled for port reuse.
// slave: the issue stage itself; master: whatever drives the window and writebacks.
interface issue_scoreboard_if #(
    parameter int unsigned ISSUE_W      = 2,
    parameter int unsigned NREGS        = 16,
    parameter int unsigned RID_W        = 4,
    parameter int unsigned WB_PORTS     = 3,
    parameter int unsigned MAX_INFLIGHT = 15
);
    logic [ISSUE_W-1:0]                   in_valid;
    logic [ISSUE_W*RID_W-1:0]             in_dst;
    logic [ISSUE_W*RID_W-1:0]             in_src0;
    logic [ISSUE_W*RID_W-1:0]             in_src1;
    logic [ISSUE_W-1:0]                   in_dst_en;
    logic [ISSUE_W-1:0]                   in_src0_en;
    logic [ISSUE_W-1:0]                   in_src1_en;
    logic [ISSUE_W-1:0]                   in_is_mem;
    logic [ISSUE_W-1:0]                   lane_busy;
    logic                                 mem_busy;
    logic [WB_PORTS-1:0]                  wb_valid;
    logic [WB_PORTS*RID_W-1:0]            wb_dst;
    logic [WB_PORTS-1:0]                  wb_dst_en;
    logic                                 flush;
    logic [ISSUE_W-1:0]                   issue_valid;
    logic [$clog2(ISSUE_W+1)-1:0]         deq_count;
    logic [NREGS-1:0]                     sb;
    logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight;
    logic                                 draining;
    logic                                 sb_err;
    logic [31:0]                          stall_cycles;

    modport master (
        output in_valid, in_dst, in_src0, in_src1, in_dst_en, in_src0_en, in_src1_en,
        output in_is_mem, lane_busy, mem_busy, wb_valid, wb_dst, wb_dst_en, flush,
        input  issue_valid, deq_count, sb, inflight, draining, sb_err, stall_cycles
    );

    modport slave (
        input  in_valid, in_dst, in_src0, in_src1, in_dst_en, in_src0_en, in_src1_en,
        input  in_is_mem, lane_busy, mem_busy, wb_valid, wb_dst, wb_dst_en, flush,
        output issue_valid, deq_count, sb, inflight, draining, sb_err, stall_cycles
    );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue stage with register scoreboard, in-flight tracking and flush drain.
// Grants a prefix of the micro-op window each cycle; blocks issue after flush until all writers retire.
module issue_scoreboard #(
    parameter int unsigned ISSUE_W      = 2,
    parameter int unsigned NREGS        = 16,
    parameter int unsigned RID_W        = 4,
    parameter int unsigned WB_PORTS     = 3,
    parameter int unsigned MEM_LANES    = 1,
    parameter int unsigned MAX_INFLIGHT = 15
) (
    input  logic              clk,
    input  logic              reset,
    issue_scoreboard_if.slave bus
);
    localparam int unsigned DEQ_W = $clog2(ISSUE_W + 1);
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [NREGS-1:0]   sb_q, sb_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               draining_q, draining_d;
    logic               sb_err_q, sb_err_d;
    logic [31:0]        stall_q, stall_d;

    logic [ISSUE_W-1:0] issue_valid;
    logic [NREGS-1:0]   grp_dst, busy, dst_m, src0_m, src1_m, wb_clear;
    logic [31:0]        n_iss, n_mem, n_wb, infl_sum, infl_next;
    logic               scan, ok, uflow;

    function automatic logic [NREGS-1:0] reg_mask(input logic [RID_W-1:0] id);
        logic [NREGS-1:0] m;
        m = '0;
        for (int unsigned r = 0; r < NREGS; r++) m[r] = (id == RID_W'(r));
        return m;
    endfunction

    // Prefix scan: the first slot that cannot go stops all younger slots.
    always_comb begin
        issue_valid = '0;
        grp_dst     = '0;
        busy        = '0;
        dst_m       = '0;
        src0_m      = '0;
        src1_m      = '0;
        ok          = 1'b0;
        n_iss       = '0;
        n_mem       = '0;
        scan        = (state_q == RUN) && !bus.flush;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            dst_m  = reg_mask(bus.in_dst[i*RID_W +: RID_W]);
            src0_m = reg_mask(bus.in_src0[i*RID_W +: RID_W]);
            src1_m = reg_mask(bus.in_src1[i*RID_W +: RID_W]);
            busy   = sb_q | grp_dst;
            ok     = scan && bus.in_valid[i];
            if (bus.in_src0_en[i] && |(src0_m & busy)) ok = 1'b0;
            if (bus.in_src1_en[i] && |(src1_m & busy)) ok = 1'b0;
            if (bus.in_dst_en[i]  && |(dst_m  & busy)) ok = 1'b0;
            if (bus.in_is_mem[i]) begin
                if (bus.mem_busy || n_mem >= MEM_LANES) ok = 1'b0;
            end else if (bus.lane_busy[i]) begin
                ok = 1'b0;
            end
            if (32'(inflight_q) + n_iss + 32'd1 > MAX_INFLIGHT) ok = 1'b0;
            if (ok) begin
                issue_valid[i] = 1'b1;
                n_iss          = n_iss + 32'd1;
                if (bus.in_is_mem[i]) n_mem = n_mem + 32'd1;
                if (bus.in_dst_en[i]) grp_dst = grp_dst | dst_m;
            end else begin
                scan = 1'b0;
            end
        end
    end

    always_comb begin
        wb_clear = '0;
        n_wb     = '0;
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (bus.wb_valid[p]) begin
                n_wb = n_wb + 32'd1;
                if (bus.wb_dst_en[p]) wb_clear = wb_clear | reg_mask(bus.wb_dst[p*RID_W +: RID_W]);
            end
        end
    end

    always_comb begin
        infl_sum  = 32'(inflight_q) + n_iss;
        uflow     = (n_wb > infl_sum);
        infl_next = uflow ? '0 : infl_sum - n_wb;
        inflight_d = CNT_W'(infl_next);
        sb_d       = (sb_q & ~wb_clear) | grp_dst;
        sb_err_d   = sb_err_q | uflow | |(wb_clear & ~sb_q);
        stall_d    = stall_q;
        if ((state_q == RUN) && !bus.flush && bus.in_valid[0] && (issue_valid == '0) && (stall_q != '1))
            stall_d = stall_q + 32'd1;
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.flush && infl_next != '0) state_d = DRAIN;
            DRAIN:   if (infl_next == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
        draining_d = (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            sb_q       <= '0;
            inflight_q <= '0;
            draining_q <= 1'b0;
            sb_err_q   <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            sb_q       <= sb_d;
            inflight_q <= inflight_d;
            draining_q <= draining_d;
            sb_err_q   <= sb_err_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.issue_valid  = issue_valid;
    assign bus.deq_count    = DEQ_W'(n_iss);
    assign bus.sb           = sb_q;
    assign bus.inflight     = inflight_q;
    assign bus.draining     = draining_q;
    assign bus.sb_err       = sb_err_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Parametrised in-order issue stage with a register scoreboard, for the dispatch slot between the micro-op decode queue and the execution pipes. Each cycle it scans a window of up to ISSUE_W queued micro-ops, grants issue in order subject to register hazards and pipe availability, and reports how many to dequeue. It tracks every in-flight op. On a flush it blocks issue until all in-flight ops have written back, so the scoreboard is never cleared under live writers.

## Interface
- ISSUE_W, 2, micro-op window / issue lanes
- NREGS, 16, scoreboard entries (architectural regs)
- RID_W, 4, register id width; NREGS <= 2**RID_W
- WB_PORTS, 3, writeback ports
- MEM_LANES, 1, max memory ops issued per cycle
- MAX_INFLIGHT, 15, in-flight op limit; counter width $clog2(MAX_INFLIGHT+1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset
- in_valid  in  ISSUE_W  window slot valid, thermometer from bit 0
- in_dst / in_src0 / in_src1  in  ISSUE_W*RID_W each  register ids, slot i at [i*RID_W +: RID_W]
- in_dst_en / in_src0_en / in_src1_en  in  ISSUE_W each  id is meaningful
- in_is_mem  in  ISSUE_W  slot targets the memory pipe
- lane_busy  in  ISSUE_W  ALU pipe i cannot accept
- mem_busy  in  1  memory pipe cannot accept
- wb_valid  in  WB_PORTS  op completed this cycle
- wb_dst  in  WB_PORTS*RID_W  completed op's destination
- wb_dst_en  in  WB_PORTS  destination meaningful
- flush  in  1  squash request (branch resteer)
- issue_valid  out  ISSUE_W  slot i issued this cycle
- deq_count  out  $clog2(ISSUE_W+1)  slots to dequeue (= popcount issue_valid)
- sb  out  NREGS  scoreboard, bit r = write to r pending
- inflight  out  $clog2(MAX_INFLIGHT+1)  ops issued, not yet written back
- draining  out  1  in DRAIN state
- sb_err  out  1  sticky: writeback to a non-pending register
- stall_cycles  out  32  perf counter

## Operation
- States: RUN, DRAIN. Issue only in RUN with flush=0.
- Slot scan i = 0..ISSUE_W-1; slot i issues iff slots 0..i-1 issued and in_valid[i] and:
  - enabled src0/src1/dst not set in sb, and not the dst of an earlier slot issued this cycle (intra-group RAW/WAW);
  - non-mem: lane_busy[i]=0; mem: mem_busy=0 and fewer than MEM_LANES mem ops already granted this cycle;
  - inflight + (issued this cycle incl. i) <= MAX_INFLIGHT.
  - First failing slot stops the scan.
- No same-cycle bypass: a writeback clears sb only from the next cycle.
- sb_next = (sb & ~wb_clear) | iss_set. wb_clear: ports with wb_valid & wb_dst_en. iss_set: issued slots with in_dst_en. The two sets are disjoint by the issue rule.
- wb_valid & wb_dst_en to a clear sb bit: the bit stays 0, sb_err sets and holds until reset.
- inflight_next = inflight + popcount(issue_valid) - popcount(wb_valid). wb_valid with dst_en=0 still decrements. Decrement below 0 clamps at 0 and sets sb_err.
- Flush in RUN: issue_valid=0 and deq_count=0 that cycle. Next state DRAIN if inflight_next != 0, else RUN. The upstream queue discards its own contents.
- DRAIN: no issue. When inflight_next == 0, go to RUN. Flush in DRAIN is ignored. sb returns to 0 naturally.
- stall_cycles increments, saturating at 0xFFFF_FFFF, on each RUN cycle with flush=0, in_valid[0]=1, and no slot issued.

## Timing
- issue_valid and deq_count are combinational from inputs and registered sb/inflight/state, in the same cycle.
- sb, inflight, state, sb_err and stall_cycles update on the rising clk edge.
- Issue-to-reissue of a dependent op: a writeback in cycle N lets the dependent op issue in N+1 at the earliest.
- Reset (async assert, deasserted synchronously by the system): state=RUN, sb=0, inflight=0, sb_err=0, stall_cycles=0, draining=0. issue_valid and deq_count follow combinationally and are 0 when in_valid=0.
- Reset mid-DRAIN returns to RUN with everything cleared; outstanding writebacks arriving afterwards set sb_err.

## Test plan
- Two independent ALU ops (dst r1, r2), lanes idle -> issue_valid=2'b11, deq_count=2, next sb=0x0006, inflight=2.
- Slot1 reads r1 written by slot0 -> only slot0 issues, deq_count=1. wb r1 in cycle N -> slot1 issues in N+1, not N.
- Two mem ops with MEM_LANES=1 -> slot0 issues, slot1 stalls. mem_busy=1 -> neither issues, stall_cycles +1.
- 3 ops in flight, flush -> draining=1, no issue despite valid inputs. Three writebacks over 3 cycles -> RUN after the last, sb=0.
- inflight=MAX_INFLIGHT-1, two valid independent ops -> exactly one issues.
- wb to r5 with sb[5]=0 -> sb unchanged, sb_err=1 and still 1 after 10 cycles. Async reset -> sb_err=0 immediately.
